// File: rtl/snake_pkg.sv
// Shared snake-game geometry constants and the apple spawner state encoding.
package snake_pkg;

  localparam int unsigned BorderThickness = 10;
  localparam int unsigned DisplayWidth    = 240;
  localparam int unsigned DisplayHeight   = 320;
  localparam int unsigned SegWidth        = 10;
  localparam int unsigned SegHeight       = 10;
  localparam int unsigned AppleWidth      = 10;
  localparam int unsigned AppleHeight     = 10;

  // Playable grid inside the border walls, in apple-sized cells.
  localparam int unsigned Cols = (DisplayWidth - 2 * BorderThickness) / AppleWidth;
  localparam int unsigned Rows = (DisplayHeight - 2 * BorderThickness) / AppleHeight;

  localparam int unsigned MaxSegments = 128;

  typedef enum logic [1:0] {
    SPAWN_IDLE   = 2'd0,
    SPAWN_PICK   = 2'd1,
    SPAWN_CHECK  = 2'd2,
    SPAWN_COMMIT = 2'd3
  } spawn_state_t;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11 (right-shifting form:
// the new MSB is the XOR of bits 0,2,3,5).
module lfsr16 #(
  parameter logic [15:0] Seed = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] state
);

  logic feedback;

  assign feedback = state[0] ^ state[2] ^ state[3] ^ state[5];

  // Shift once per clock; the seed must be non-zero or the register locks up.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= Seed;
    else       state <= {feedback, state[15:1]};
  end

endmodule

// File: rtl/apple_spawner.sv
// Apple spawner: after each eat pulse draws random grid cells from an LFSR,
// rejects any cell touching a live snake segment (one segment per clock) and
// commits the first free one as the new apple location.
module apple_spawner
  import snake_pkg::spawn_state_t, snake_pkg::SPAWN_IDLE, snake_pkg::SPAWN_PICK,
         snake_pkg::SPAWN_CHECK, snake_pkg::SPAWN_COMMIT;
#(
  parameter int unsigned BorderThickness = snake_pkg::BorderThickness,
  parameter int unsigned DisplayWidth    = snake_pkg::DisplayWidth,
  parameter int unsigned DisplayHeight   = snake_pkg::DisplayHeight,
  parameter int unsigned AppleWidth      = snake_pkg::AppleWidth,
  parameter int unsigned AppleHeight     = snake_pkg::AppleHeight,
  parameter logic [15:0] LfsrSeed        = 16'hACE1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          appleEaten,
  input  logic [1023:0] snakeLocX,
  input  logic [1152:0] snakeLocY,
  input  logic [7:0]    size,
  output logic [7:0]    appleLocX,
  output logic [8:0]    appleLocY,
  output logic          appleValid,
  output logic          busy
);

  localparam int unsigned XW       = 8;
  localparam int unsigned YW       = 9;
  localparam int unsigned IdxW     = 7;
  localparam int unsigned NumCols  = (DisplayWidth - 2 * BorderThickness) / AppleWidth;
  localparam int unsigned NumRows  = (DisplayHeight - 2 * BorderThickness) / AppleHeight;
  localparam int unsigned LastSeg  = snake_pkg::MaxSegments - 1;
  localparam int unsigned ResetCol = 10;
  localparam int unsigned ResetRow = 24;

  spawn_state_t    state, state_next;
  logic [15:0]     lfsr_value;
  logic [XW-1:0]   cand_x, cand_x_next, loc_x_next;
  logic [YW-1:0]   cand_y, cand_y_next, loc_y_next;
  logic [IdxW-1:0] idx, idx_next, last_idx, last_idx_next, snap_last;
  logic            valid_next;
  logic [4:0]      pick_col, pick_row;
  logic            pick_ok;
  logic [XW-1:0]   pick_x, seg_x;
  logic [YW-1:0]   pick_y, seg_y;
  logic signed [XW:0] dx;
  logic signed [YW:0] dy;
  logic [XW:0]     adx;
  logic [YW:0]     ady;
  logic            overlap;
  logic            unused_lfsr_bits;

  lfsr16 #(.Seed(LfsrSeed)) u_lfsr (
    .clock (clock),
    .reset (reset),
    .state (lfsr_value)
  );

  // Candidate cell from the LFSR and its pixel position.
  assign pick_col         = lfsr_value[4:0];
  assign pick_row         = lfsr_value[12:8];
  assign unused_lfsr_bits = ^{lfsr_value[15:13], lfsr_value[7:5]};
  assign pick_ok          = (32'(pick_col) < NumCols) && (32'(pick_row) < NumRows);
  assign pick_x           = XW'(BorderThickness + 32'(pick_col) * AppleWidth);
  assign pick_y           = YW'(BorderThickness + 32'(pick_row) * AppleHeight);

  // Index of the last segment to scan: size clamped to [1, MaxSegments].
  assign snap_last = (size == 8'd0)                          ? '0 :
                     (32'(size) >= snake_pkg::MaxSegments)   ? IdxW'(LastSeg) :
                                                               IdxW'(size - 8'd1);

  // Segment under test and its distance to the candidate, widened so nothing wraps.
  assign seg_x   = snakeLocX[{idx, 3'b000} +: XW];
  assign seg_y   = snakeLocY[11'(idx) * 11'd9 +: YW];
  assign dx      = $signed({1'b0, seg_x}) - $signed({1'b0, cand_x});
  assign dy      = $signed({1'b0, seg_y}) - $signed({1'b0, cand_y});
  assign adx     = dx[XW] ? $unsigned(-dx) : $unsigned(dx);
  assign ady     = dy[YW] ? $unsigned(-dy) : $unsigned(dy);
  assign overlap = (32'(adx) < AppleWidth) && (32'(ady) < AppleHeight);

  // State, candidate, scan pointer and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= SPAWN_IDLE;
      cand_x     <= '0;
      cand_y     <= '0;
      idx        <= '0;
      last_idx   <= '0;
      appleLocX  <= XW'(BorderThickness + ResetCol * AppleWidth);
      appleLocY  <= YW'(BorderThickness + ResetRow * AppleHeight);
      appleValid <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      cand_x     <= cand_x_next;
      cand_y     <= cand_y_next;
      idx        <= idx_next;
      last_idx   <= last_idx_next;
      appleLocX  <= loc_x_next;
      appleLocY  <= loc_y_next;
      appleValid <= valid_next;
      busy       <= (state_next != SPAWN_IDLE);
    end
  end

  // Next-state logic: pick, scan the snake, commit.
  always_comb begin
    state_next    = state;
    cand_x_next   = cand_x;
    cand_y_next   = cand_y;
    idx_next      = idx;
    last_idx_next = last_idx;
    loc_x_next    = appleLocX;
    loc_y_next    = appleLocY;
    valid_next    = appleValid;
    case (state)
      SPAWN_IDLE: begin
        if (appleEaten) begin
          state_next = SPAWN_PICK;
          valid_next = 1'b0;
        end
      end
      SPAWN_PICK: begin
        if (pick_ok) begin
          cand_x_next   = pick_x;
          cand_y_next   = pick_y;
          idx_next      = '0;
          last_idx_next = snap_last;
          state_next    = SPAWN_CHECK;
        end
      end
      SPAWN_CHECK: begin
        if (overlap)               state_next = SPAWN_PICK;
        else if (idx == last_idx)  state_next = SPAWN_COMMIT;
        else                       idx_next   = idx + 7'd1;
      end
      SPAWN_COMMIT: begin
        loc_x_next = cand_x;
        loc_y_next = cand_y;
        valid_next = 1'b1;
        state_next = SPAWN_IDLE;
      end
      default: state_next = SPAWN_IDLE;
    endcase
  end

endmodule

// File: tb/tb_apple_spawner.sv
// Scoreboard bench for apple_spawner: a transaction-level model predicts the
// committed cell and its completion cycle for each eat pulse; a monitor checks
// every rising appleValid against the queued prediction.
module tb_apple_spawner;

  localparam logic [15:0] Seed = 16'hACE1;
  localparam int Border = 10;
  localparam int Cell   = 10;
  localparam int NCols  = 22;
  localparam int NRows  = 30;

  logic          clock = 1'b0;
  logic          reset;
  logic          appleEaten;
  logic [1023:0] snakeLocX;
  logic [1152:0] snakeLocY;
  logic [7:0]    size;
  logic [7:0]    appleLocX;
  logic [8:0]    appleLocY;
  logic          appleValid;
  logic          busy;

  apple_spawner dut (
    .clock      (clock),
    .reset      (reset),
    .appleEaten (appleEaten),
    .snakeLocX  (snakeLocX),
    .snakeLocY  (snakeLocY),
    .size       (size),
    .appleLocX  (appleLocX),
    .appleLocY  (appleLocY),
    .appleValid (appleValid),
    .busy       (busy)
  );

  always #10 clock = ~clock;

  typedef struct {
    int x;
    int y;
    int due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   commits = 0;
  logic prev_valid = 1'b1;
  logic [15:0] m_lfsr;
  int   seg_x[128];
  int   seg_y[128];
  int   last_e, last_edges, last_fx, last_fy;
  int   fx, fy, c0, p, n, sz, kk;

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Fibonacci LFSR, taps 16,14,13,11, bits shifting toward bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  function automatic int iabs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  // Reference LFSR value after each clock edge.
  always @(posedge clock or posedge reset) begin
    if (reset) m_lfsr <= Seed;
    else       m_lfsr <= lfsr_next(m_lfsr);
  end

  always @(posedge clock) cyc <= cyc + 1;

  // First in-range cell drawn from an LFSR sequence starting at 'start'.
  task automatic find_first(input logic [15:0] start, output int cx, output int cy);
    logic [15:0] v;
    v  = start;
    cx = -1;
    cy = -1;
    for (int i = 0; i < 70000 && cx < 0; i++) begin
      if (int'(v[4:0]) < NCols && int'(v[12:8]) < NRows) begin
        cx = Border + int'(v[4:0]) * Cell;
        cy = Border + int'(v[12:8]) * Cell;
      end
      v = lfsr_next(v);
    end
  endtask

  // Whole-transaction model: draws, range rejection, per-segment scan with one
  // LFSR step per cycle; returns the committed cell and edges until appleValid.
  task automatic predict(input logic [15:0] start, input int szi,
                         output int ex, output int ey, output int edges);
    logic [15:0] v;
    int s, cnt, cx, cy;
    bit done, hit;
    v    = start;
    s    = (szi == 0) ? 1 : ((szi > 128) ? 128 : szi);
    cnt  = 0;
    done = 0;
    ex   = -1;
    ey   = -1;
    while (!done && cnt < 60000) begin
      cx = int'(v[4:0]);
      cy = int'(v[12:8]);
      v  = lfsr_next(v);
      cnt++;
      if (cx < NCols && cy < NRows) begin
        cx  = Border + cx * Cell;
        cy  = Border + cy * Cell;
        hit = 0;
        for (int i = 0; i < s && !hit; i++) begin
          v = lfsr_next(v);
          cnt++;
          if (iabs(seg_x[i] - cx) < Cell && iabs(seg_y[i] - cy) < Cell) hit = 1;
        end
        if (!hit) begin
          done = 1;
          ex   = cx;
          ey   = cy;
        end
      end
    end
    edges = cnt + 1;
  endtask

  task automatic pack();
    snakeLocX = '0;
    snakeLocY = '0;
    for (int i = 0; i < 128; i++) begin
      snakeLocX[i*8 +: 8] = 8'(seg_x[i]);
      snakeLocY[i*9 +: 9] = 9'(seg_y[i]);
    end
  endtask

  // Issue one eat pulse (call just after a negedge with the DUT idle).
  task automatic spawn(input int szi);
    int ex, ey, ed;
    exp_t it;
    size = 8'(szi);
    pack();
    appleEaten = 1'b1;
    @(posedge clock);
    #1;
    appleEaten = 1'b0;
    predict(m_lfsr, szi, ex, ey, ed);
    it.x   = ex;
    it.y   = ey;
    it.due = cyc + ed;
    sb.push_back(it);
    last_e     = cyc;
    last_edges = ed;
    chk("busy_after_eat", int'(busy), 1);
    chk("valid_drop", int'(appleValid), 0);
  endtask

  task automatic wait_idle(input string name);
    int w;
    w = 0;
    do begin
      @(negedge clock);
      w++;
    end while ((busy || sb.size() != 0) && w < 4000);
    if (w >= 4000) begin
      chk({name, "_timeout"}, 1, 0);
      sb.delete();
    end
  endtask

  // Monitor: every new commit must match the oldest outstanding prediction.
  always @(negedge clock) begin
    if (reset) begin
      prev_valid = 1'b1;
    end else begin
      if (appleValid && !prev_valid) begin
        commits++;
        if (sb.size() == 0) begin
          chk("unexpected_commit", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("apple_x", int'(appleLocX), mon_e.x);
          chk("apple_y", int'(appleLocY), mon_e.y);
          chk("commit_cycle", cyc, mon_e.due);
          chk("x_on_grid", (int'(appleLocX) - Border) % Cell, 0);
          chk("y_on_grid", (int'(appleLocY) - Border) % Cell, 0);
          chk("x_in_range", int'(appleLocX >= 8'd10 && appleLocX <= 8'd220), 1);
          chk("y_in_range", int'(appleLocY >= 9'd10 && appleLocY <= 9'd300), 1);
        end
      end
      prev_valid = appleValid;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    appleEaten = 1'b0;
    size       = 8'd1;
    for (int i = 0; i < 128; i++) begin
      seg_x[i] = 0;
      seg_y[i] = 0;
    end
    pack();
    repeat (3) @(negedge clock);
    chk("rst_loc_x", int'(appleLocX), 110);
    chk("rst_loc_y", int'(appleLocY), 250);
    chk("rst_valid", int'(appleValid), 1);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b0;
    chk("rst_lfsr_seed", int'(dut.u_lfsr.state), int'(Seed));

    // Single spawn, head at (100,160).
    @(negedge clock);
    seg_x[0] = 100;
    seg_y[0] = 160;
    spawn(1);
    wait_idle("single");

    // Overlap rejection: segment 2 sits exactly on the first candidate.
    find_first(lfsr_next(m_lfsr), fx, fy);
    seg_x[0] = (fx >= 120) ? 10 : 210;
    seg_y[0] = fy;
    seg_x[1] = fx;
    seg_y[1] = (fy >= 160) ? 10 : 300;
    seg_x[2] = fx;
    seg_y[2] = fy;
    spawn(3);
    wait_idle("overlap");
    chk("overlap_moved", int'(int'(appleLocX) == fx && int'(appleLocY) == fy), 0);
    for (int i = 0; i < 3; i++)
      chk("overlap_free", int'(iabs(int'(appleLocX) - seg_x[i]) < Cell &&
                               iabs(int'(appleLocY) - seg_y[i]) < Cell), 0);

    // Out-of-range rejection: wait until the first draw has col >= 22.
    n = 0;
    while (lfsr_next(m_lfsr) % 16'd32 < 16'd22 && n < 500) begin
      @(negedge clock);
      n++;
    end
    spawn(1);
    @(posedge clock);
    #1;
    chk("pick_retry", int'(dut.state), int'(snake_pkg::SPAWN_PICK));
    wait_idle("range");
    chk("range_col", int'((int'(appleLocX) - Border) / Cell < NCols), 1);

    // Repeated pulses while busy: only one commit.
    @(negedge clock);
    c0 = commits;
    seg_x[1] = 10 + 10 * $urandom_range(0, 21);
    seg_y[1] = 10 + 10 * $urandom_range(0, 29);
    spawn(2);
    for (int k = 0; k < 600; k++) begin
      @(negedge clock);
      if (!busy) break;
      appleEaten = 1'($urandom_range(0, 1));
    end
    appleEaten = 1'b0;
    repeat (20) @(negedge clock);
    chk("ignored_commits", commits, c0 + 1);
    chk("ignored_busy", int'(busy), 0);
    chk("ignored_queue", sb.size(), 0);

    // Randomized spawns against the model.
    for (int t = 0; t < 20; t++) begin
      sz = (t == 7) ? 200 : int'($urandom_range(0, 10));
      for (int i = 0; i < 128; i++) begin
        if ($urandom_range(0, 1) == 0) begin
          seg_x[i] = 10 + 10 * $urandom_range(0, 21);
          seg_y[i] = 10 + 10 * $urandom_range(0, 29);
        end else begin
          seg_x[i] = $urandom_range(0, 255);
          seg_y[i] = $urandom_range(0, 511);
        end
      end
      if ($urandom_range(0, 1) == 1) begin
        find_first(lfsr_next(m_lfsr), fx, fy);
        kk = $urandom_range(0, ((sz == 0) ? 1 : ((sz > 128) ? 128 : sz)) - 1);
        seg_x[kk] = fx;
        seg_y[kk] = fy;
      end
      spawn(sz);
      wait_idle("random");
    end

    // Full-length scan interrupted by an asynchronous reset at idx 60.
    find_first(lfsr_next(m_lfsr), fx, fy);
    for (int i = 0; i < 128; i++) begin
      seg_x[i] = (fx == 10) ? 20 : 10;
      seg_y[i] = fy;
    end
    spawn(128);
    p = last_edges - 128 - 1;
    repeat (p + 60) @(posedge clock);
    @(negedge clock);
    chk("mid_check_state", int'(dut.state), int'(snake_pkg::SPAWN_CHECK));
    chk("mid_check_idx", int'(dut.idx), 60);
    c0 = commits;
    reset = 1'b1;
    #1;
    chk("async_loc_x", int'(appleLocX), 110);
    chk("async_loc_y", int'(appleLocY), 250);
    chk("async_valid", int'(appleValid), 1);
    chk("async_busy", int'(busy), 0);
    sb.delete();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst2_lfsr_seed", int'(dut.u_lfsr.state), int'(Seed));
    repeat (200) @(negedge clock);
    chk("no_commit_after_rst", commits, c0);
    chk("post_rst_loc_x", int'(appleLocX), 110);
    chk("post_rst_valid", int'(appleValid), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apple_spawner.md
Name: apple_spawner

Overview:
Owns the apple position consumed by the collision detector. On each appleEaten pulse it picks a new grid-aligned cell inside the border walls using a free-running 16-bit LFSR. It rejects candidates that overlap any live snake segment by scanning the serialized snake arrays one segment per clock. It then commits the new appleLocX/appleLocY.

Parameters:
- BorderThickness, 10, wall thickness in pixels.
- DisplayWidth, 240, display width in pixels (x axis).
- DisplayHeight, 320, display height in pixels (y axis).
- AppleWidth, 10, apple and grid cell width in pixels.
- AppleHeight, 10, apple and grid cell height in pixels.
- LfsrSeed, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- clock  input  1  50 MHz system clock.
- reset  input  1  asynchronous, active-high game reset.
- appleEaten  input  1  eat pulse from the collision detector.
- snakeLocX  input  1024  8 bits per segment; segment i occupies [i*8+7:i*8]; index 0 is the head.
- snakeLocY  input  1153  9 bits per segment; segment i occupies [i*9+8:i*9].
- size  input  8  number of live segments.
- appleLocX  output  8  apple x position in pixels.
- appleLocY  output  9  apple y position in pixels.
- appleValid  output  1  high when appleLoc is committed and stable.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: reset reset, asynchronous, active-high; clock clock. All state is on posedge clock.
- Grid geometry:
  - Cols = (DisplayWidth-2*BorderThickness)/AppleWidth = 22.
  - Rows = (DisplayHeight-2*BorderThickness)/AppleHeight = 30.
  - x = BorderThickness + col*AppleWidth.
  - y = BorderThickness + row*AppleHeight.
- Reset values: appleLocX=110 (col 10), appleLocY=250 (row 24), appleValid=1, busy=0, state=IDLE, lfsr=LfsrSeed, scan index=0.
- LFSR:
  - Fibonacci form, taps 16,14,13,11.
  - Shifts every clock in every state, reset excepted.
  - Candidate col = lfsr[4:0], row = lfsr[12:8].
- State machine (IDLE, PICK, CHECK, COMMIT):
  - IDLE: on appleEaten=1 go to PICK and set appleValid<=0. appleLoc holds its old value.
  - PICK:
    - If col<Cols and row<Rows: latch candidate pixel coordinates, snapshot size, set idx=0, go to CHECK.
    - Otherwise stay in PICK and retry next cycle.
  - CHECK, one segment per cycle:
    - Overlap test is |segX-candX|<AppleWidth AND |segY-candY|<AppleHeight.
    - Compute differences at 9/10 bits; no truncation wrap.
    - Overlap: go to PICK.
    - No overlap and idx==snapshotSize-1: go to COMMIT.
    - Otherwise: idx<=idx+1.
  - COMMIT: appleLocX/Y <= candidate, appleValid<=1, go to IDLE.
- Scan length:
  - snapshotSize = min(size,128).
  - size==0 is treated as 1, so the head is always checked.
  - Later size changes are ignored for the current scan.
- Latency:
  - appleEaten sampled at edge E means PICK at E+1.
  - If the first candidate is accepted with no overlap: CHECK runs E+2..E+1+S, COMMIT at E+2+S.
  - appleValid is high after edge E+2+S.
- busy equals (state != IDLE).
- appleEaten while busy is ignored; no queuing.
- appleEaten in the same cycle COMMIT completes is ignored, because the state is not IDLE.
- Reset mid-operation returns all state to reset values immediately and asynchronously.
- Termination: the snake has at most 128 segments against 660 cells, so a free cell always exists. No retry limit.

Decomposition:
- Shared package (snake_pkg) holds:
  - display geometry constants: BorderThickness, DisplayWidth, DisplayHeight, SegWidth, SegHeight, AppleWidth, AppleHeight;
  - derived Cols and Rows;
  - MaxSegments=128;
  - the spawner state encoding.
- One sub-module is natural: lfsr16. It has clock, reset, the seed parameter and a 16-bit state output, and is reused for any other randomness in the game.

Test Plan:
- Reset:
  - Assert reset mid-run, release.
  - Required: appleLocX=110, appleLocY=250, appleValid=1, busy=0; lfsr equals 16'hACE1 on the first post-reset edge.
- Single spawn:
  - size=1, head (100,160), pulse appleEaten.
  - Required: busy rises at E+1; if the first in-range candidate is accepted with no overlap, appleValid returns at E+3.
  - Required: the new location matches the bench LFSR model, lies on the grid, and satisfies 10<=x<=220 and 10<=y<=300.
- Overlap rejection:
  - Bench model predicts the first accepted candidate; place segment 2 of size=3 exactly on it.
  - Required: CHECK returns to PICK at idx 2, and the committed location differs and overlaps no segment.
- Out-of-range rejection:
  - Force a seed giving lfsr[4:0]>=22.
  - Required: PICK holds at least one extra cycle and the committed col<22.
- Ignored pulse:
  - Pulse appleEaten repeatedly while busy.
  - Required: exactly one COMMIT, then IDLE, with appleLoc updated once.
- Full-length scan:
  - size=128, reset asynchronously mid-CHECK at idx 60.
  - Required: outputs return to reset values without waiting for a clock edge, and no COMMIT occurs.
